serv_ctrl_wide: RTL



---
 rtl/serv_ctrl_wide_if.sv | 44 ++++
 rtl/serv_ctrl_wide.sv | 124 ++++++++++++
 2 files changed

// File: rtl/serv_ctrl_wide_if.sv
// Bundle between decode/state, serv_ctrl_wide and the instruction bus.
// SERV_CTRL_COMPRESSED_EN adds the i_compressed strobe.
interface serv_ctrl_wide_if #(
  parameter int W = 1
) ();
  // No valid/ready pair here. i_pc_en qualifies every input chunk, and the
  // unit consumes that chunk on the same rising edge. o_rd describes the
  // chunk currently presented. o_done is a one-cycle pulse after the final
  // chunk. o_ibus_adr is only a stable address while no update is in flight.
  logic         i_pc_en;
  logic         i_jump;
  logic         i_jal_or_jalr;
  logic         i_utype;
  logic         i_pc_rel;
  logic         i_trap;
  logic [W-1:0] i_imm;
  logic [W-1:0] i_buf;
  logic [W-1:0] i_csr_pc;
`ifdef SERV_CTRL_COMPRESSED_EN
  logic         i_compressed;
`endif
  logic [W-1:0] o_rd;
  logic         o_bad_pc;
  logic         o_done;
  logic [31:0]  o_ibus_adr;

  modport master (
    output i_pc_en, i_jump, i_jal_or_jalr, i_utype, i_pc_rel, i_trap,
           i_imm, i_buf, i_csr_pc,
`ifdef SERV_CTRL_COMPRESSED_EN
    output i_compressed,
`endif
    input  o_rd, o_bad_pc, o_done, o_ibus_adr
  );

  modport slave (
    input  i_pc_en, i_jump, i_jal_or_jalr, i_utype, i_pc_rel, i_trap,
           i_imm, i_buf, i_csr_pc,
`ifdef SERV_CTRL_COMPRESSED_EN
    input  i_compressed,
`endif
    output o_rd, o_bad_pc, o_done, o_ibus_adr
  );
endinterface

// File: rtl/serv_ctrl_wide.sv
// Chunked (W = 1/2/4 bits per enabled cycle) PC / link / U-type unit.
// Optional feature macro: SERV_CTRL_COMPRESSED_EN (PC+2 for 16-bit instructions, no bit-1 fault).
module serv_ctrl_wide #(
  parameter int          W        = 1,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter bit          WITH_CSR = 1'b1
) (
  input  logic            clk,
  input  logic            i_rst,
  serv_ctrl_wide_if.slave bus
);
  localparam int N       = 32 / W;
  localparam int CW      = $clog2(N);
  localparam int UCNT    = 12 / W;
  localparam int B1_CNT  = (W == 1) ? 1 : 0;
  localparam int B1_POS  = (W == 1) ? 0 : 1;

  generate
    if (!(W == 1 || W == 2 || W == 4)) begin : g_bad_w
      $error("serv_ctrl_wide: W must be 1, 2 or 4");
    end
    if ($bits(bus.i_imm) != W) begin : g_bad_if_w
      $error("serv_ctrl_wide: interface W differs from module W");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;
  logic          cy4_q, cy4_d;
  logic          cyo_q, cyo_d;
  logic [31:0]   adr_q, adr_d;
  logic          bad_q, bad_d;
  logic          done_q, done_d;

  logic          first_c;
  logic          trap_eff;
  logic [31:0]   inc_word;
  logic [31:0]   inc_sh;
  logic [W-1:0]  pc_c, inc_c, a_c, b_c;
  logic [W:0]    sum4, sumo;
  logic [W-1:0]  p4, po, po_al, csr_al, new_c;
  logic          bad_set;

  always_comb begin
    first_c  = (cnt_q == '0);
    trap_eff = WITH_CSR && bus.i_trap;
`ifdef SERV_CTRL_COMPRESSED_EN
    inc_word = bus.i_compressed ? 32'd2 : 32'd4;
`else
    inc_word = 32'd4;
`endif
    inc_sh = inc_word >> (W * int'(cnt_q));
    inc_c  = inc_sh[W-1:0];
    pc_c   = adr_q[W-1:0];

    // Carry-in is forced to zero on chunk 0 so nothing leaks between updates.
    sum4 = {1'b0, pc_c} + {1'b0, inc_c} + {{W{1'b0}}, (first_c ? 1'b0 : cy4_q)};
    p4   = sum4[W-1:0];

    a_c = bus.i_pc_rel ? pc_c : '0;
    if (bus.i_utype) b_c = (cnt_q >= CW'(UCNT)) ? bus.i_imm : '0;
    else             b_c = bus.i_buf;
    sumo = {1'b0, a_c} + {1'b0, b_c} + {{W{1'b0}}, (first_c ? 1'b0 : cyo_q)};
    po   = sumo[W-1:0];

    po_al  = po;
    csr_al = bus.i_csr_pc;
    if (first_c) begin
      po_al[0]  = 1'b0;
      csr_al[0] = 1'b0;
    end

    if (trap_eff)         new_c = csr_al;
    else if (bus.i_jump)  new_c = po_al;
    else                  new_c = p4;

    bus.o_rd = (bus.i_utype ? po : '0) | (bus.i_jal_or_jalr ? p4 : '0);

`ifdef SERV_CTRL_COMPRESSED_EN
    bad_set = 1'b0;
`else
    bad_set = bus.i_jump && !trap_eff && (cnt_q == CW'(B1_CNT)) && po[B1_POS];
`endif
  end

  always_comb begin
    cnt_d  = cnt_q;
    cy4_d  = cy4_q;
    cyo_d  = cyo_q;
    adr_d  = adr_q;
    bad_d  = bad_q;
    done_d = 1'b0;
    if (bus.i_pc_en) begin
      cnt_d  = cnt_q + CW'(1);
      cy4_d  = sum4[W];
      cyo_d  = sumo[W];
      adr_d  = {new_c, adr_q[31:W]};
      done_d = (cnt_q == CW'(N - 1));
      if (first_c) bad_d = 1'b0;
      if (bad_set) bad_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      cy4_q  <= 1'b0;
      cyo_q  <= 1'b0;
      adr_q  <= RESET_PC;
      bad_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cy4_q  <= cy4_d;
      cyo_q  <= cyo_d;
      adr_q  <= adr_d;
      bad_q  <= bad_d;
      done_q <= done_d;
    end
  end

  assign bus.o_ibus_adr = adr_q;
  assign bus.o_bad_pc   = bad_q;
  assign bus.o_done     = done_q;
endmodule
